// File: rtl/gpr_pkg.sv
// gpr_pkg: shared register-file constants, grant encoding and arbiter state type
package gpr_pkg;
  localparam int XLEN = 64;
  localparam int REG_ADDR_W = 5;
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_A = 2'b01;
  localparam logic [1:0] GNT_B = 2'b10;
  typedef enum logic {ARB_NORMAL, ARB_BOOST} arb_state_e;
endpackage

// File: rtl/gpr_wb_starve.sv
// gpr_wb_starve: starvation counter and NORMAL/BOOST state for the write-back arbiter port B
module gpr_wb_starve
  import gpr_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic b_valid,
  input  logic b_ready,
  input  logic b_xfer,
  output logic boost
);
  localparam logic [3:0] MAX = 4'(STARVE_MAX);
  arb_state_e state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic inc;
  always_comb begin
    inc = state == ARB_NORMAL && b_valid && !b_ready;
    cnt_nxt = (b_xfer || (state == ARB_BOOST && !b_valid)) ? 4'd0 :
              (inc && cnt != MAX) ? cnt + 4'd1 : cnt;
    state_nxt = state == ARB_BOOST ? ((b_xfer || !b_valid) ? ARB_NORMAL : ARB_BOOST) :
                (inc && cnt == MAX - 4'd1) ? ARB_BOOST : ARB_NORMAL;
    boost = state == ARB_BOOST;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ARB_NORMAL;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
    end
endmodule

// File: rtl/gpr_wb_arb.sv
// gpr_wb_arb: GPR write-port arbiter, A fixed priority, registered write-back stage.
// Define GPR_WB_STARVE_EN to compile in the port-B starvation guard (BOOST state).
module gpr_wb_arb
  import gpr_pkg::*;
#(
  parameter int XLEN = gpr_pkg::XLEN,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  a_valid_i,
  output logic                  a_ready_o,
  input  logic [REG_ADDR_W-1:0] a_rd_i,
  input  logic [XLEN-1:0]       a_data_i,
  input  logic                  b_valid_i,
  output logic                  b_ready_o,
  input  logic [REG_ADDR_W-1:0] b_rd_i,
  input  logic [XLEN-1:0]       b_data_i,
  output logic [REG_ADDR_W-1:0] Rd_o,
  output logic [XLEN-1:0]       Rd_data_o,
  output logic                  Rd_wen_o,
  output logic [1:0]            grant_o
);
  logic a_xfer, b_xfer, boost;
  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_cfg
    $error("gpr_wb_arb: STARVE_MAX must be within 1..15");
  end
`ifdef GPR_WB_STARVE_EN
  gpr_wb_starve #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk(clk_i),
    .rst(rst_i),
    .b_valid(b_valid_i),
    .b_ready(b_ready_o),
    .b_xfer(b_xfer),
    .boost(boost)
  );
`else
  assign boost = 1'b0;
`endif
  // The write port never stalls, so ready depends only on the valids and the state.
  always_comb begin
    a_ready_o = boost ? !b_valid_i : 1'b1;
    b_ready_o = boost || !a_valid_i;
    a_xfer = a_valid_i && a_ready_o;
    b_xfer = b_valid_i && b_ready_o;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      Rd_o <= '0;
      Rd_data_o <= '0;
      Rd_wen_o <= 1'b0;
      grant_o <= GNT_NONE;
    end else begin
      Rd_wen_o <= (a_xfer && a_rd_i != '0) || (b_xfer && b_rd_i != '0);
      grant_o <= a_xfer ? GNT_A : b_xfer ? GNT_B : GNT_NONE;
      if (a_xfer || b_xfer) begin
        Rd_o <= a_xfer ? a_rd_i : b_rd_i;
        Rd_data_o <= a_xfer ? a_data_i : b_data_i;
      end
    end
endmodule

// File: tb/tb_gpr_wb_arb.sv
// tb_gpr_wb_arb: directed and randomized checks of gpr_wb_arb against a refusal-count model
module tb_gpr_wb_arb;
  import gpr_pkg::*;
  localparam int SMAX = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic a_valid = 0, b_valid = 0, a_ready, b_ready, Rd_wen;
  logic [4:0] a_rd = 0, b_rd = 0, Rd;
  logic [63:0] a_data = 0, b_data = 0, Rd_data;
  logic [1:0] grant;
  int errs = 0, checks = 0;
  int m_ref, b_grants;
  logic [4:0] e_rd;
  logic [63:0] e_data;
  logic e_wen, ax, bx;
  logic [1:0] e_gnt;

  always #5 clk = ~clk;

  gpr_wb_arb #(.XLEN(64), .STARVE_MAX(SMAX)) dut (
    .clk_i(clk), .rst_i(rst),
    .a_valid_i(a_valid), .a_ready_o(a_ready), .a_rd_i(a_rd), .a_data_i(a_data),
    .b_valid_i(b_valid), .b_ready_o(b_ready), .b_rd_i(b_rd), .b_data_i(b_data),
    .Rd_o(Rd), .Rd_data_o(Rd_data), .Rd_wen_o(Rd_wen), .grant_o(grant)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // B is forced through once it has been refused STARVE_MAX times since its last grant
  function automatic logic m_boost();
`ifdef GPR_WB_STARVE_EN
    return m_ref == SMAX;
`else
    return 1'b0;
`endif
  endfunction

  task automatic m_reset();
    m_ref = 0; e_rd = 0; e_data = 0; e_wen = 0; e_gnt = 0;
  endtask

  task automatic chk_out();
    chk("Rd_o", 64'(Rd), 64'(e_rd));
    chk("Rd_data_o", Rd_data, e_data);
    chk("Rd_wen_o", 64'(Rd_wen), 64'(e_wen));
    chk("grant_o", 64'(grant), 64'(e_gnt));
  endtask

  task automatic step();
    logic ar, br, bst;
    @(negedge clk);
    bst = m_boost();
    ar = bst ? !b_valid : 1'b1;
    br = bst || !a_valid;
    chk("a_ready_o", 64'(a_ready), 64'(ar));
    chk("b_ready_o", 64'(b_ready), 64'(br));
    ax = a_valid && ar;
    bx = b_valid && br;
    @(posedge clk);
    if (bst || bx) m_ref = 0;
    else if (b_valid) m_ref++;
    if (ax) begin e_rd = a_rd; e_data = a_data; end
    else if (bx) begin e_rd = b_rd; e_data = b_data; end
    e_wen = ax ? a_rd != 0 : bx ? b_rd != 0 : 1'b0;
    e_gnt = ax ? GNT_A : bx ? GNT_B : GNT_NONE;
    if (bx) b_grants++;
    #1 chk_out();
  endtask

  task automatic mid_reset();
    #1 rst = 1'b1;
    #1 m_reset();
    chk_out();
    chk("rst a_ready_o", 64'(a_ready), 64'd1);
    chk("rst b_ready_o", 64'(b_ready), 64'(!a_valid));
    #1 rst = 1'b0;
  endtask

  initial begin
    m_reset();
    #12;
    chk_out();
    rst = 1'b0;
    a_valid = 1; a_rd = 5; a_data = 64'h1234;
    step();
    chk("single A Rd", 64'(Rd), 64'd5);
    chk("single A data", Rd_data, 64'h1234);
    chk("single A grant", 64'(grant), 64'(GNT_A));
    a_valid = 0;
    step();
    b_valid = 1; b_rd = 0; b_data = 64'hFFFF;
    step();
    chk("x0 wen", 64'(Rd_wen), 64'd0);
    chk("x0 grant", 64'(grant), 64'(GNT_B));
    a_valid = 1; a_rd = 3; a_data = 64'hAAAA; b_rd = 7; b_data = 64'hBBBB;
    step();
    chk("collide first", 64'(grant), 64'(GNT_A));
    a_valid = 0;
    step();
    chk("collide second", 64'(grant), 64'(GNT_B));
    chk("collide wen", 64'(Rd_wen), 64'd1);
    b_valid = 0;
    step();
    b_grants = 0;
    b_valid = 1; b_rd = 9; b_data = 64'h9999;
    for (int i = 0; i < 20; i++) begin
      a_valid = 1; a_rd = 5'(i + 1); a_data = {$urandom, $urandom};
      step();
    end
`ifdef GPR_WB_STARVE_EN
    chk("starve B grants", 64'(b_grants), 64'd4);
`else
    chk("starve B grants", 64'(b_grants), 64'd0);
`endif
    for (int i = 0; i < 10 && !m_boost(); i++) step();
    mid_reset();
    step();
    chk("post reset grant", 64'(grant), 64'(GNT_A));
    for (int i = 0; i < 500; i++) begin
      if (!a_valid || ax) begin
        a_valid = ($urandom % 4) != 0;
        a_rd = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom);
        a_data = {$urandom, $urandom};
      end
      if (!b_valid || bx || $urandom % 16 == 0) begin
        b_valid = ($urandom % 2) != 0;
        b_rd = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom);
        b_data = {$urandom, $urandom};
      end
      step();
      if ($urandom % 50 == 0) mid_reset();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
